// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
// Holds the loader state encoding and the serial CRC-16-CCITT step function.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first CRC-16-CCITT update for a single input bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator: one bit per enabled cycle, synchronous re-init.
// Init takes priority over enable so a restart always begins from CRC16_INIT.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, din);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto ccff_head for exactly CHAIN_LEN shift cycles.
// Optional macro CCFF_TAIL_CRC_EN builds a CRC-16 of the old chain contents seen on ccff_tail.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              cfg_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [15:0]       tail_crc
);

    localparam int unsigned NB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [NB_W-1:0]   nb_q, nb_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_ok;

    // Bits of the next word that actually reach the chain: min(WORD_W, remaining).
    function automatic logic [NB_W-1:0] word_bits(input logic [CNT_W-1:0] rem);
        if (32'(rem) >= WORD_W) begin
            return NB_W'(WORD_W);
        end
        return NB_W'(rem);
    endfunction

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        nb_d         = nb_q;
        sreg_d       = sreg_q;
        busy_d       = busy_q;
        done_d       = done_q;
        word_ready   = 1'b0;
        cfg_shift_en = 1'b0;
        start_ok     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_ok = 1'b1;
                    state_d  = LOAD;
                    rem_d    = CHAIN_LEN_C;
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            LOAD: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    sreg_d  = word_in;
                    nb_d    = word_bits(rem_q);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cfg_shift_en = 1'b1;
                sreg_d       = sreg_q << 1;
                rem_d        = rem_q - CNT_W'(1);
                nb_d         = nb_q - NB_W'(1);
                if (nb_q == NB_W'(1)) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Offer the next word during the last bit so back-to-back words never bubble.
                        word_ready = 1'b1;
                        if (word_valid) begin
                            sreg_d = word_in;
                            nb_d   = word_bits(rem_q - CNT_W'(1));
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            nb_q    <= '0;
            sreg_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            nb_q    <= nb_d;
            sreg_q  <= sreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ccff_head = (state_q == SHIFT) && sreg_q[WORD_W-1];
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CCFF_TAIL_CRC_EN
    logic [15:0] crc_val;

    ccff_crc16_serial u_crc (
        .clk  (prog_clk),
        .rst  (prog_reset),
        .init (start_ok),
        .en   (cfg_shift_en),
        .din  (ccff_tail),
        .crc  (crc_val)
    );

    // Only presented once the load has finished; the register itself idles at CRC16_INIT.
    assign tail_crc = done_q ? crc_val : 16'h0000;
`else
    logic unused_crc_inputs;
    assign unused_crc_inputs = ccff_tail ^ start_ok;
    assign tail_crc          = 16'h0000;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: a 20-bit chain loader (with a chain model on ccff_tail) and a 16-bit one.
module tb_ccff_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        prog_reset;
    logic        start_a, valid_a, ready_a, head_a, sen_a, tail_a, busy_a, done_a;
    logic [7:0]  word_a;
    logic [15:0] crc_a;
    logic        start_b, valid_b, ready_b, head_b, sen_b, tail_b, busy_b, done_b;
    logic [7:0]  word_b;
    logic [15:0] crc_b;

    logic [19:0] chain = '0;
    assign tail_a = chain[19];
    assign tail_b = 1'b0;

    always @(posedge clk) begin
        if (sen_a) chain <= {chain[18:0], head_a};
    end

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut_a (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_a), .word_in(word_a),
        .word_valid(valid_a), .word_ready(ready_a), .ccff_head(head_a),
        .cfg_shift_en(sen_a), .ccff_tail(tail_a), .busy(busy_a), .done(done_a),
        .tail_crc(crc_a)
    );

    ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut_b (
        .prog_clk(clk), .prog_reset(prog_reset), .start(start_b), .word_in(word_b),
        .word_valid(valid_b), .word_ready(ready_b), .ccff_head(head_b),
        .cfg_shift_en(sen_b), .ccff_tail(tail_b), .busy(busy_b), .done(done_b),
        .tail_crc(crc_b)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          first_acc_a, first_acc_b;
    int          shifts_a, shifts_b, rem_a, rem_b;
    bit          exp_a[$];
    bit          exp_b[$];
    logic [15:0] crc_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic b);
        logic [15:0] r;
        r = c ^ {b, 15'b0};
        if (r[15]) r = (r << 1) ^ 16'h1021;
        else       r = r << 1;
        return r;
    endfunction

    // Advance to the next negedge and score any bit shifted out this cycle.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sen_a) begin
            if (exp_a.size() == 0) check("a_extra_shift", 1, 0);
            else check("a_head", head_a, exp_a.pop_front());
            shifts_a++;
            crc_m = ref_crc(crc_m, tail_a);
        end
        if (sen_b) begin
            if (exp_b.size() == 0) check("b_extra_shift", 1, 0);
            else check("b_head", head_b, exp_b.pop_front());
            shifts_b++;
            if (shifts_b == 16) check("b_ready_last", ready_b, 0);
        end
    endtask

    task automatic start_pulse_a();
        rem_a = 20; shifts_a = 0; crc_m = 16'hFFFF;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] w, input int stall);
        int n;
        for (int c = 0; c < 100 && !ready_a; c++) tick();
        repeat (stall == 0 ? 0 : stall + 1) tick();
        if (!ready_a) begin
            check("a_ready_timeout", ready_a, 1);
            return;
        end
        if (rem_a == 20) first_acc_a = cyc;
        n = (rem_a < 8) ? rem_a : 8;
        for (int i = 0; i < n; i++) exp_a.push_back(w[7-i]);
        rem_a -= n;
        word_a = w; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
    endtask

    task automatic finish_a(input int lat);
        logic [15:0] want_crc;
        for (int c = 0; c < 200 && !done_a; c++) tick();
        check("a_done_lat", 32'(cyc - first_acc_a), 32'(lat));
        check("a_shifts", 32'(shifts_a), 20);
        check("a_queue_empty", 32'(exp_a.size()), 0);
        check("a_busy_end", busy_a, 0);
        check("a_chain", 32'(chain), 32'h000A53CF);
`ifdef CCFF_TAIL_CRC_EN
        want_crc = crc_m;
`else
        want_crc = 16'h0000;
`endif
        check("a_tail_crc", 32'(crc_a), 32'(want_crc));
    endtask

    task automatic send_b(input logic [7:0] w);
        int n;
        for (int c = 0; c < 100 && !ready_b; c++) tick();
        if (!ready_b) begin
            check("b_ready_timeout", ready_b, 1);
            return;
        end
        if (rem_b == 16) first_acc_b = cyc;
        n = (rem_b < 8) ? rem_b : 8;
        for (int i = 0; i < n; i++) exp_b.push_back(w[7-i]);
        rem_b -= n;
        word_b = w; valid_b = 1'b1;
        tick();
        valid_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] want_b;
        prog_reset = 1'b1;
        start_a = 1'b0; valid_a = 1'b0; word_a = '0;
        start_b = 1'b0; valid_b = 1'b0; word_b = '0;
        shifts_a = 0; shifts_b = 0; rem_a = 20; rem_b = 16; crc_m = 16'hFFFF;
        tick(); tick();
        check("rst_ready", ready_a, 0);
        check("rst_head", head_a, 0);
        check("rst_shift_en", sen_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_crc", 32'(crc_a), 0);
        prog_reset = 1'b0;
        tick();
        check("idle_ready", ready_a, 0);

        // Back-to-back full load of 20 bits.
        start_pulse_a();
        check("a_busy_start", busy_a, 1);
        send_a(8'hA5, 0); send_a(8'h3C, 0); send_a(8'hF0, 0);
        finish_a(21);

        // Same load with 3-cycle gaps in word_valid between words.
        start_pulse_a();
        check("a_done_cleared", done_a, 0);
        send_a(8'hA5, 0); send_a(8'h3C, 3); send_a(8'hF0, 3);
        finish_a(29);

        // Ignored start mid-shift, then reset after 10 shifts.
        start_pulse_a();
        send_a(8'hA5, 0); send_a(8'h3C, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("a_ign_start_busy", busy_a, 1);
        check("a_shifts_before_rst", 32'(shifts_a), 10);
        #1 prog_reset = 1'b1;
        #1;
        check("mid_rst_ready", ready_a, 0);
        check("mid_rst_head", head_a, 0);
        check("mid_rst_shift_en", sen_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        exp_a.delete();
        tick(); tick();
        prog_reset = 1'b0;
        tick();
        start_pulse_a();
        send_a(8'hA5, 0); send_a(8'h3C, 0); send_a(8'hF0, 0);
        finish_a(21);

        // Exact multiple: 16-bit chain, FF then 00.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        shifts_b = 0;
        send_b(8'hFF); send_b(8'h00);
        for (int c = 0; c < 200 && !done_b; c++) tick();
        check("b_done_lat", 32'(cyc - first_acc_b), 17);
        check("b_shifts", 32'(shifts_b), 16);
        check("b_queue_empty", 32'(exp_b.size()), 0);
        want_b = 16'hFFFF;
`ifdef CCFF_TAIL_CRC_EN
        for (int i = 0; i < 16; i++) want_b = ref_crc(want_b, 1'b0);
`else
        want_b = 16'h0000;
`endif
        check("b_tail_crc", 32'(crc_b), 32'(want_b));
        repeat (5) tick();
        check("b_done_held", done_b, 1);
        check("b_ready_done", ready_b, 0);
        check("b_shift_en_done", sen_b, 0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("b_done_after_start", done_b, 0);
        check("b_busy_after_start", busy_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
